data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-requester arbiter that shares the single-ported `data_memory` between the CPU load/store stage (port 0) and the program/debug loader (port 1). Sits directly in front of `data_memory`, owns its `address`/`write_data`/`write_enable` inputs, and returns read data and a one-cycle acknowledge to the winning requester. Grants are round-robin with a bounded burst allowance so neither side can starve the other.

## Interface
- `DATA_WIDTH`, 32, data bus width.
- `ADDR_WIDTH`, 32, address bus width.
- `MAX_BURST`, 4, max consecutive grants to one port while the other is requesting (≥1).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_0` / `req_1`  in  1  access request, held until ack.
- `write_enable_0` / `write_enable_1`  in  1  1 = write, 0 = read; stable while req high.
- `address_0` / `address_1`  in  ADDR_WIDTH  word address; stable while req high.
- `write_data_0` / `write_data_1`  in  DATA_WIDTH  write data; stable while req high.
- `ack_0` / `ack_1`  out  1  high for exactly the ACCESS cycle of that port's transaction.
- `read_data_0` / `read_data_1`  out  DATA_WIDTH  registered read data, updated at end of that port's read ACCESS, held otherwise.
- `mem_address`  out  ADDR_WIDTH  to `data_memory.address`.
- `mem_write_data`  out  DATA_WIDTH  to `data_memory.write_data`.
- `mem_write_enable`  out  1  to `data_memory.write_enable`.
- `mem_read_data`  in  DATA_WIDTH  from `data_memory.read_data` (combinational read).
- `busy`  out  1  high in ACCESS.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: if neither req → stay. Else pick winner, latch its address/write_data/write_enable and port id, go ACCESS.
- Winner choice: only one req → that port. Both → the port not granted last, unless last port's burst_count < MAX_BURST, then the last port keeps it.
- burst_count: set to 1 on grant to a different port than last, incremented (saturating at MAX_BURST) on grant to the same port.
- ACCESS: mem_* driven from latch; mem_write_enable = latched write_enable; ack of owner high. Always return to IDLE at end of cycle.
- Read: owner's read_data register loads mem_read_data at the edge ending ACCESS. Write: memory commits at that edge; read_data unchanged.
- In IDLE: mem_address = 0, mem_write_data = 0, mem_write_enable = 0.
- Requester protocol: drop or change req/fields only after sampling ack high at a rising edge. Fields changing while req high and not yet acked are undefined behaviour (latched values win once granted).

## Timing
- Reset values: state IDLE, all ack 0, busy 0, mem_* 0, read_data_0/1 = 0, last grant = port 1 (so port 0 wins first tie), burst_count = 0.
- Latency: req sampled high at edge E0 (in IDLE) → ack high E0..E1 → write committed / read_data valid after E1. Two cycles per transaction; peak one transaction every 2 cycles.
- req deasserted in IDLE before being sampled → no access, no ack.
- Reset asserted during ACCESS: immediately IDLE, ack and mem_write_enable drop combinationally with reset; pending write is not committed; requester must reissue.
- MAX_BURST = 1 → strict alternation under continuous contention.

## Structure
- Shared package `mips_mem_pkg`: state encoding (IDLE, ACCESS), port id constants (PORT_CPU = 0, PORT_LOADER = 1).
- Sub-module `round_robin_picker`: combinational, inputs req_0/req_1, last port, burst_count, MAX_BURST; outputs valid and winner id.
- Top instantiates the picker plus FSM, latch, burst counter and read_data registers; no memory inside.

## Test plan
- Single write then read, port 0: write 0xAABB_CCDD to address 1, then read address 1 → ack_0 one cycle each, read_data_0 = 0xAABB_CCDD, ack_1 never high.
- Simultaneous first request: both req at cycle after reset, port 0 write 0x1111_1111 @2, port 1 write 0xFFFF_FFFF @3 → port 0 granted first, then port 1; memory holds both values.
- Burst limit, MAX_BURST = 4: port 0 and port 1 both request continuously → grant sequence 0,0,0,0,1,1,1,1,0…; port 0 held alone → unlimited consecutive grants.
- Read data hold: port 1 reads 0x1234_5678 @5, then port 0 does ten transactions → read_data_1 stays 0x1234_5678.
- Reset mid-write: port 1 write 0xDEAD_BEEF @7, assert reset during ACCESS → ack_1 and mem_write_enable go low immediately, address 7 unchanged, all outputs at reset values.
- Dropped request: port 0 pulses req for half a cycle between edges → no grant, no ack, mem_write_enable stays 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Definitions shared by the data memory arbiter and its round-robin picker:
// arbiter FSM state encoding and requester port identifiers.
//
// Contents:
//   arb_state_e  - arbiter FSM states (ST_IDLE, ST_ACCESS)
//   PORT_CPU     - port id of the CPU load/store stage (port 0)
//   PORT_LOADER  - port id of the program/debug loader (port 1)
//   burst_width  - width needed to count 0..max_burst
// -----------------------------------------------------------------------------
package mips_mem_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } arb_state_e;

   localparam logic PORT_CPU    = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

   // Counter width able to hold every value from 0 up to max_burst inclusive.
   function automatic int burst_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage : mips_mem_pkg

// File: rtl/round_robin_picker.sv
// -----------------------------------------------------------------------------
// round_robin_picker
// Combinational winner selection for the two-port data memory arbiter.
// A lone requester always wins. When both request, the port granted last keeps
// the memory while its run of consecutive grants is still below MAX_BURST;
// otherwise the other port takes over.
//
// Ports:
//   req_0, req_1   in   access requests from port 0 / port 1
//   last_port      in   port id of the most recent grant
//   burst_count    in   consecutive grants already given to last_port
//   valid          out  at least one port is requesting
//   winner         out  port id that should be granted
// -----------------------------------------------------------------------------
module round_robin_picker
   import mips_mem_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int BURST_W   = 3
) (
   input  logic               req_0,
   input  logic               req_1,
   input  logic               last_port,
   input  logic [BURST_W-1:0] burst_count,
   output logic               valid,
   output logic               winner
);

   localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(MAX_BURST);

   logic keep_last_s;

   // Winner selection; a zero burst count means nothing has been granted since
   // reset, so the reset value of last_port (loader) yields the tie to the CPU.
   always_comb begin
      keep_last_s = (burst_count != '0) && (burst_count < BURST_MAX_C);
      valid       = req_0 | req_1;
      winner      = PORT_CPU;
      if (req_0 && req_1) begin
         if (keep_last_s) begin
            winner = last_port;
         end else begin
            winner = ~last_port;
         end
      end else if (req_1) begin
         winner = PORT_LOADER;
      end else begin
         winner = PORT_CPU;
      end
   end

endmodule : round_robin_picker

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Shares one single-ported, combinationally-read data memory between the CPU
// load/store stage (port 0) and the program/debug loader (port 1). Every
// transaction takes two cycles: an IDLE cycle in which the request is sampled
// and latched, then an ACCESS cycle in which the memory is driven from the
// latch and the owner's ack is high. Reads land in the owner's read_data
// register at the edge that ends ACCESS; writes commit in memory at that edge.
//
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   req_x, write_enable_x,
//   address_x, write_data_x           request channel of port x (0 = CPU,
//                                     1 = loader); held until ack
//   ack_x                             high during port x's ACCESS cycle
//   read_data_x                       last read result returned to port x
//   mem_address, mem_write_data,
//   mem_write_enable                  drive the data memory (zero while idle)
//   mem_read_data                     combinational read data from memory
//   busy                              high during ACCESS
// -----------------------------------------------------------------------------
module data_memory_arbiter
   import mips_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_0,
   input  logic                  req_1,
   input  logic                  write_enable_0,
   input  logic                  write_enable_1,
   input  logic [ADDR_WIDTH-1:0] address_0,
   input  logic [ADDR_WIDTH-1:0] address_1,
   input  logic [DATA_WIDTH-1:0] write_data_0,
   input  logic [DATA_WIDTH-1:0] write_data_1,
   output logic                  ack_0,
   output logic                  ack_1,
   output logic [DATA_WIDTH-1:0] read_data_0,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  busy
);

   localparam int                 BURST_W     = burst_width(MAX_BURST);
   localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] BURST_ONE_C = BURST_W'(1);

   arb_state_e            state_q,  state_d;
   logic                  owner_q,  owner_d;
   logic                  last_q,   last_d;
   logic [BURST_W-1:0]    burst_q,  burst_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
   logic                  we_q,     we_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

   logic pick_valid_s;
   logic pick_winner_s;

   round_robin_picker #(
      .MAX_BURST (MAX_BURST),
      .BURST_W   (BURST_W)
   ) u_picker (
      .req_0       (req_0),
      .req_1       (req_1),
      .last_port   (last_q),
      .burst_count (burst_q),
      .valid       (pick_valid_s),
      .winner      (pick_winner_s)
   );

   // Next-state logic: grant and latch in IDLE, retire the access in ACCESS.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      burst_d  = burst_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_d = ST_ACCESS;
               owner_d = pick_winner_s;
               last_d  = pick_winner_s;
               if (pick_winner_s == PORT_LOADER) begin
                  addr_d  = address_1;
                  wdata_d = write_data_1;
                  we_d    = write_enable_1;
               end else begin
                  addr_d  = address_0;
                  wdata_d = write_data_0;
                  we_d    = write_enable_0;
               end
               // Run length restarts on a port change and saturates otherwise.
               if (pick_winner_s != last_q) begin
                  burst_d = BURST_ONE_C;
               end else if (burst_q < BURST_MAX_C) begin
                  burst_d = burst_q + BURST_ONE_C;
               end else begin
                  burst_d = burst_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            state_d = ST_IDLE;
            if (!we_q) begin
               if (owner_q == PORT_LOADER) begin
                  rdata1_d = mem_read_data;
               end else begin
                  rdata0_d = mem_read_data;
               end
            end else begin
               rdata0_d = rdata0_q;
               rdata1_d = rdata1_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, request latch, grant history and read data registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= PORT_CPU;
         last_q   <= PORT_LOADER;
         burst_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         burst_q  <= burst_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Output decode from registered state; the async reset clears state_q at
   // once, so ack and mem_write_enable fall together with reset.
   always_comb begin
      ack_0            = 1'b0;
      ack_1            = 1'b0;
      busy             = 1'b0;
      mem_address      = '0;
      mem_write_data   = '0;
      mem_write_enable = 1'b0;
      if (state_q == ST_ACCESS) begin
         busy             = 1'b1;
         ack_0            = (owner_q == PORT_CPU);
         ack_1            = (owner_q == PORT_LOADER);
         mem_address      = addr_q;
         mem_write_data   = wdata_q;
         mem_write_enable = we_q;
      end else begin
         busy             = 1'b0;
         mem_address      = '0;
         mem_write_data   = '0;
         mem_write_enable = 1'b0;
      end
   end

   assign read_data_0 = rdata0_q;
   assign read_data_1 = rdata1_q;

endmodule : data_memory_arbiter

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
// Directed scenarios followed by random two-port traffic. A transaction-level
// model (grant history queue, reference memory image) predicts every output
// each cycle; a 16-word memory array stands in for data_memory.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MB = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_0 = 1'b0, req_1 = 1'b0;
   logic          write_enable_0 = 1'b0, write_enable_1 = 1'b0;
   logic [AW-1:0] address_0 = '0, address_1 = '0;
   logic [DW-1:0] write_data_0 = '0, write_data_1 = '0;
   logic          ack_0, ack_1, busy, mem_write_enable;
   logic [DW-1:0] read_data_0, read_data_1, mem_write_data, mem_read_data;
   logic [AW-1:0] mem_address;

   logic [31:0] tb_mem  [0:15] = '{default: 32'h0};
   logic [31:0] ref_mem [0:15] = '{default: 32'h0};

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   data_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
      .clock            (clock),
      .reset            (reset),
      .req_0            (req_0),
      .req_1            (req_1),
      .write_enable_0   (write_enable_0),
      .write_enable_1   (write_enable_1),
      .address_0        (address_0),
      .address_1        (address_1),
      .write_data_0     (write_data_0),
      .write_data_1     (write_data_1),
      .ack_0            (ack_0),
      .ack_1            (ack_1),
      .read_data_0      (read_data_0),
      .read_data_1      (read_data_1),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data),
      .busy             (busy)
   );

   // Memory stand-in: combinational read, write on rising edge.
   assign mem_read_data = tb_mem[mem_address[3:0]];
   always @(posedge clock) begin
      if (mem_write_enable) tb_mem[mem_address[3:0]] <= mem_write_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   bit          m_acc   = 1'b0;
   bit          m_owner = 1'b0;
   bit          m_we    = 1'b0;
   logic [31:0] m_addr  = '0, m_wdata = '0, m_rd0 = '0, m_rd1 = '0;
   int          glog[$];

   task automatic model_reset();
      m_acc = 1'b0; m_owner = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
      glog.delete();
   endtask

   // Who wins: lone requester; on a tie the previous winner keeps going while
   // its consecutive-grant run is below MB, else the other port. No history
   // after reset means port 0 wins the tie.
   function automatic int pick_port(input bit r0, input bit r1);
      int last;
      int run;
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
      if (glog.size() == 0) return 0;
      last = glog[glog.size()-1];
      run  = 0;
      for (int i = glog.size() - 1; i >= 0; i--) begin
         if (glog[i] != last) break;
         run++;
      end
      return (run < MB) ? last : 1 - last;
   endfunction

   task automatic model_step();
      int w;
      if (m_acc) begin
         if (m_we) ref_mem[m_addr[3:0]] = m_wdata;
         else if (m_owner) m_rd1 = ref_mem[m_addr[3:0]];
         else m_rd0 = ref_mem[m_addr[3:0]];
         m_acc = 1'b0;
      end else if (req_0 || req_1) begin
         w       = pick_port(req_0, req_1);
         m_owner = (w == 1);
         m_we    = (w == 1) ? write_enable_1 : write_enable_0;
         m_addr  = (w == 1) ? address_1 : address_0;
         m_wdata = (w == 1) ? write_data_1 : write_data_0;
         m_acc   = 1'b1;
         glog.push_back(w);
         while (glog.size() > MB) void'(glog.pop_front());
      end
   endtask

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare and grant monitor ----------------
   int grant_seen[$];
   bit a0_last = 1'b0, a1_last = 1'b0;

   initial begin
      forever begin
         @(negedge clock);
         chk("ack_0",    32'(ack_0),            32'(m_acc && !m_owner));
         chk("ack_1",    32'(ack_1),            32'(m_acc && m_owner));
         chk("busy",     32'(busy),             32'(m_acc));
         chk("mem_addr", mem_address,           m_acc ? m_addr : 32'h0);
         chk("mem_wdat", mem_write_data,        m_acc ? m_wdata : 32'h0);
         chk("mem_we",   32'(mem_write_enable), 32'(m_acc && m_we));
         chk("rd0",      read_data_0,           m_rd0);
         chk("rd1",      read_data_1,           m_rd1);
         a0_last = ack_0;
         a1_last = ack_1;
         if (ack_0) grant_seen.push_back(0);
         if (ack_1) grant_seen.push_back(1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_point();
      @(posedge clock);
      #2;
   endtask

   task automatic set_port(input int p, input bit r, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         req_0 = r; write_enable_0 = we; address_0 = a; write_data_0 = d;
      end else begin
         req_1 = r; write_enable_1 = we; address_1 = a; write_data_1 = d;
      end
   endtask

   task automatic wait_ack(input int p);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         if ((p == 0) ? ack_0 : ack_1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL ack_timeout port %0d: got no ack, expected one within 20 cycles", p);
      end
   endtask

   task automatic txn(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
      set_port(p, 1'b1, we, a, d);
      wait_ack(p);
      drive_point();
      set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_point();
      drive_point();
      reset = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          exp_pat[10];
      logic [31:0] old9;
      exp_pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

      // Reset state
      @(negedge clock);
      #1;
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_ack0",  32'(ack_0), 32'h0);
      chk("rst_maddr", mem_address, 32'h0);
      chk("rst_rd1",   read_data_1, 32'h0);
      drive_point();
      reset = 1'b0;

      // Port 0 write then read
      grant_seen.delete();
      txn(0, 1'b1, 32'd1, 32'hAABB_CCDD);
      txn(0, 1'b0, 32'd1, 32'h0);
      chk("t1_rd0",    read_data_0, 32'hAABB_CCDD);
      chk("t1_grants", 32'(grant_seen.size()), 32'd2);
      foreach (grant_seen[i]) chk("t1_no_port1", 32'(grant_seen[i]), 32'd0);

      // Simultaneous first request after reset
      do_reset();
      grant_seen.delete();
      set_port(0, 1'b1, 1'b1, 32'd2, 32'h1111_1111);
      set_port(1, 1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF);
      wait_ack(0);
      drive_point();
      set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_ack(1);
      drive_point();
      set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_first",  32'(grant_seen[0]), 32'd0);
      chk("t2_second", 32'(grant_seen[1]), 32'd1);
      chk("t2_mem2",   tb_mem[2], 32'h1111_1111);
      chk("t2_mem3",   tb_mem[3], 32'hFFFF_FFFF);

      // Burst limit under continuous contention, then port 0 alone
      do_reset();
      grant_seen.delete();
      set_port(0, 1'b1, 1'b0, 32'd2, 32'h0);
      set_port(1, 1'b1, 1'b0, 32'd3, 32'h0);
      repeat (20) drive_point();
      set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_count", 32'(grant_seen.size()), 32'd10);
      for (int i = 0; i < 10 && i < grant_seen.size(); i++)
         chk("t3_pattern", 32'(grant_seen[i]), 32'(exp_pat[i]));
      drive_point();
      grant_seen.delete();
      set_port(0, 1'b1, 1'b0, 32'd3, 32'h0);
      repeat (12) drive_point();
      set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_alone_count", 32'(grant_seen.size()), 32'd6);
      foreach (grant_seen[i]) chk("t3_alone_port", 32'(grant_seen[i]), 32'd0);

      // Read data hold on port 1
      txn(1, 1'b1, 32'd5, 32'h1234_5678);
      txn(1, 1'b0, 32'd5, 32'h0);
      chk("t4_rd1", read_data_1, 32'h1234_5678);
      for (int i = 0; i < 10; i++)
         txn(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
      chk("t4_rd1_hold", read_data_1, 32'h1234_5678);

      // Reset during a port 1 write to address 7
      txn(0, 1'b1, 32'd7, 32'h0000_0777);
      set_port(1, 1'b1, 1'b1, 32'd7, 32'hDEAD_BEEF);
      wait_ack(1);
      #1;
      reset = 1'b1;
      set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("t5_ack1",  32'(ack_1), 32'h0);
      chk("t5_we",    32'(mem_write_enable), 32'h0);
      chk("t5_busy",  32'(busy), 32'h0);
      chk("t5_maddr", mem_address, 32'h0);
      chk("t5_rd1",   read_data_1, 32'h0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      chk("t5_mem7", tb_mem[7], 32'h0000_0777);

      // Request pulse that never meets a rising edge
      old9 = tb_mem[9];
      grant_seen.delete();
      set_port(0, 1'b1, 1'b1, 32'd9, 32'hCAFE_0009);
      #4;
      set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) begin
         @(negedge clock);
         chk("t6_ack0", 32'(ack_0), 32'h0);
         chk("t6_we",   32'(mem_write_enable), 32'h0);
      end
      chk("t6_grants", 32'(grant_seen.size()), 32'd0);
      drive_point();
      chk("t6_mem9", tb_mem[9], old9);

      // Random traffic from both requesters
      for (int c = 0; c < 600; c++) begin
         if (req_0 && a0_last) begin
            if ($urandom_range(0, 1) == 1)
               set_port(0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            else
               set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
         end else if (!req_0 && $urandom_range(0, 9) < 4) begin
            set_port(0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
         end
         if (req_1 && a1_last) begin
            if ($urandom_range(0, 1) == 1)
               set_port(1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            else
               set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
         end else if (!req_1 && $urandom_range(0, 9) < 4) begin
            set_port(1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
         end
         drive_point();
      end
      set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) drive_point();

      for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_data_memory_arbiter
